// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifq_pkg;

   localparam int IFQ_ADDR_W  = 8;
   localparam int IFQ_INSTR_W = 16;

   localparam logic [IFQ_INSTR_W-1:0] IFQ_NOP = '0;

   typedef struct packed {
      logic [IFQ_ADDR_W-1:0]  pc;
      logic [IFQ_INSTR_W-1:0] instr;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous prefetch FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter type T     = ifq_entry_t,
   parameter int  DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  T                           data_i,
   input  logic                       pop_i,
   output T                           head_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   T              mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   // Guards keep the storage consistent even if a caller misbehaves.
   assign pop_ok  = pop_i & (count_q != '0);
   assign push_ok = push_i & ((count_q != DEPTH_C) | pop_ok);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + 1'b1;
         if (pop_ok)  rptr_d = rptr_q + 1'b1;
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) mem_q[wptr_q] <= data_i;
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC, imem issue with credit check, prefetch queue to decode, redirect flush.
// Optional IFQ_PERF_EN adds the perf_stall_cnt decode-starvation counter.
module instr_fetch_queue
   import ifq_pkg::*;
#(
   parameter int                ADDR_W   = IFQ_ADDR_W,
   parameter int                INSTR_W  = IFQ_INSTR_W,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_en,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc
`ifdef IFQ_PERF_EN
   ,
   output logic [15:0]        perf_stall_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   logic [ADDR_W-1:0] pc_q, pc_d, fetch_pc_q, fetch_pc_d;
   logic              inflight_q, inflight_d, kill_q, kill_d;
   logic [CW-1:0]     count;
   logic [CW:0]       occ;
   entry_t            head, push_data;
   logic              push, pop, credit, issue;

   // Entries already queued plus the one in flight must never exceed DEPTH.
   assign occ      = {1'b0, count} + (CW+1)'(inflight_q);
   assign id_valid = (count != '0) & ~redirect_valid & ~reset;
   assign pop      = id_valid & id_ready;
   assign credit   = (occ < DEPTH_C) | ((occ == DEPTH_C) & pop);
   assign issue    = fetch_en & ~redirect_valid & ~reset & credit;

   assign imem_req  = issue;
   assign imem_addr = pc_q;

   assign push      = inflight_q & ~kill_q & ~redirect_valid & ~reset;
   assign push_data = '{pc: fetch_pc_q, instr: imem_rdata};

   assign id_pc    = id_valid ? head.pc    : '0;
   assign id_instr = id_valid ? head.instr : INSTR_W'(IFQ_NOP);

   always_comb begin
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      inflight_d = 1'b0;
      kill_d     = 1'b0;
      if (redirect_valid) begin
         pc_d   = redirect_pc;
         kill_d = inflight_q;
      end else if (issue) begin
         fetch_pc_d = pc_q;
         pc_d       = pc_q + 1'b1;
         inflight_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         fetch_pc_q <= '0;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
      end
   end

   ifq_fifo #(
      .T     (entry_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .flush_i (redirect_valid),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (count)
   );

`ifdef IFQ_PERF_EN
   logic [15:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (!id_valid && perf_q != 16'hFFFF) perf_d = perf_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) perf_q <= '0;
      else       perf_q <= perf_d;
   end

   assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, back-to-back redirect, random vs queue model.
module tb_instr_fetch_queue;

   localparam int         DEPTH = 4;
   localparam logic [7:0] RPC   = 8'hFE;

   logic        clk = 1'b0;
   logic        reset = 1'b1, fetch_en = 1'b0, redirect_valid = 1'b0, id_ready = 1'b0;
   logic        imem_req, id_valid;
   logic [7:0]  imem_addr, id_pc, redirect_pc = '0;
   logic [15:0] imem_rdata = '0, id_instr;
`ifdef IFQ_PERF_EN
   logic [15:0] perf;
`endif

   always #5 clk = ~clk;

   instr_fetch_queue #(.ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc)
`ifdef IFQ_PERF_EN
      ,
      .perf_stall_cnt (perf)
`endif
   );

   function automatic logic [15:0] f(input logic [7:0] a);
      return {~a, a};
   endfunction

   // Synchronous instruction memory: word at address a holds f(a).
   always @(posedge clk) if (imem_req) imem_rdata <= f(imem_addr);

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a queue of fetched words plus at most one outstanding fetch.
   typedef struct packed {logic [7:0] pc; logic [15:0] instr;} ent_t;
   ent_t       mq[$];
   logic [7:0] m_pc = RPC, m_pend_pc = '0;
   bit         m_pend = 0;
   int         m_perf = 0;

   task automatic step(input bit rst, input bit fe, input bit rv, input logic [7:0] rpc,
                       input bit rdy);
      bit         e_req, e_valid, pop;
      logic [7:0] e_pc;
      logic [15:0] e_instr;
      @(negedge clk);
      reset = rst; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
      #1;
      if (rst) begin
         e_req = 0; e_valid = 0; pop = 0; e_pc = '0; e_instr = '0;
      end else begin
         e_valid = (mq.size() != 0) && !rv;
         pop     = e_valid && rdy;
         e_req   = fe && !rv && ((mq.size() + int'(m_pend) < DEPTH) ||
                                 (mq.size() + int'(m_pend) == DEPTH && pop));
         e_pc    = e_valid ? mq[0].pc : 8'h00;
         e_instr = e_valid ? mq[0].instr : 16'h0000;
      end
      chk("imem_req", imem_req, e_req);
      chk("id_valid", id_valid, e_valid);
      chk("id_pc", id_pc, e_pc);
      chk("id_instr", id_instr, e_instr);
      if (!rst) chk("imem_addr", imem_addr, m_pc);
`ifdef IFQ_PERF_EN
      if (!rst) chk("perf_stall_cnt", perf, m_perf);
`endif
      if (rst) begin
         mq.delete(); m_pc = RPC; m_pend = 0; m_perf = 0;
      end else begin
         if (!e_valid && m_perf < 65535) m_perf++;
         if (rv) begin
            mq.delete(); m_pc = rpc; m_pend = 0;
         end else begin
            if (pop) void'(mq.pop_front());
            if (m_pend) mq.push_back(ent_t'{m_pend_pc, f(m_pend_pc)});
            m_pend = e_req;
            if (e_req) begin m_pend_pc = m_pc; m_pc = m_pc + 8'd1; end
         end
      end
   endtask

   typedef struct {
      bit rst, fe, rv; logic [7:0] rpc; bit rdy;
      bit e_req; logic [7:0] e_addr; bit e_valid; logic [7:0] e_pc;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t V(bit rst, bit fe, bit rv, logic [7:0] rpc, bit rdy,
                              bit er, logic [7:0] ea, bit ev, logic [7:0] ep);
      vec_t v;
      v.rst = rst; v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
      v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
      return v;
   endfunction

   initial begin
      // reset, stream across the 0xFF->0x00 wrap
      tbl.push_back(V(1,1,0,8'h00,1, 0,8'h00,0,8'h00));
      tbl.push_back(V(1,1,0,8'h00,1, 0,8'h00,0,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'hFE,0,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'hFF,0,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h00,1,8'hFE));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h01,1,8'hFF));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h02,1,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h03,1,8'h01));
      // backpressure: fills to DEPTH then stops issuing
      tbl.push_back(V(0,1,0,8'h00,0, 1,8'h04,1,8'h02));
      tbl.push_back(V(0,1,0,8'h00,0, 1,8'h05,1,8'h02));
      tbl.push_back(V(0,1,0,8'h00,0, 0,8'h00,1,8'h02));
      tbl.push_back(V(0,1,0,8'h00,0, 0,8'h00,1,8'h02));
      tbl.push_back(V(0,1,0,8'h00,0, 0,8'h00,1,8'h02));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h06,1,8'h02));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h07,1,8'h03));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h08,1,8'h04));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h09,1,8'h05));
      // redirect with 3 queued + 1 in flight
      tbl.push_back(V(0,1,1,8'h40,1, 0,8'h00,0,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h40,0,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h41,0,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h42,1,8'h40));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h43,1,8'h41));
      // fetch_en low: in-flight word still lands, then drain and resume
      tbl.push_back(V(0,0,0,8'h00,1, 0,8'h00,1,8'h42));
      tbl.push_back(V(0,0,0,8'h00,1, 0,8'h00,1,8'h43));
      tbl.push_back(V(0,0,0,8'h00,1, 0,8'h00,0,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h44,0,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h45,0,8'h00));
      // fill, then reset with a full queue
      tbl.push_back(V(0,1,0,8'h00,0, 1,8'h46,1,8'h44));
      tbl.push_back(V(0,1,0,8'h00,0, 1,8'h47,1,8'h44));
      tbl.push_back(V(0,1,0,8'h00,0, 0,8'h00,1,8'h44));
      tbl.push_back(V(1,1,0,8'h00,0, 0,8'h00,0,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'hFE,0,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'hFF,0,8'h00));
      tbl.push_back(V(0,1,0,8'h00,1, 1,8'h00,1,8'hFE));

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].fe, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
         chk($sformatf("vec%0d_req", i), imem_req, tbl[i].e_req);
         if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
         chk($sformatf("vec%0d_valid", i), id_valid, tbl[i].e_valid);
         if (tbl[i].e_valid) begin
            chk($sformatf("vec%0d_pc", i), id_pc, tbl[i].e_pc);
            chk($sformatf("vec%0d_instr", i), id_instr, f(tbl[i].e_pc));
         end
      end
`ifdef IFQ_PERF_EN
      // two starved cycles after the reset release above
      chk("perf_after_reset", perf, 32'd2);
`endif

      // back-to-back redirects: the second target wins
      begin
         bit seen = 0;
         step(0,1,1,8'h10,1);
         step(0,1,1,8'h80,1);
         for (int k = 0; k < 8 && !seen; k++) begin
            step(0,1,0,8'h00,1);
            seen = id_valid;
         end
         chk("b2b_redirect_seen", seen, 1);
         if (seen) chk("b2b_redirect_pc0", id_pc, 8'h80);
         step(0,1,0,8'h00,1);
         chk("b2b_redirect_pc1", id_pc, 8'h81);
      end

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(99) == 0, $urandom_range(9) != 0, $urandom_range(19) == 0,
              8'($urandom), $urandom_range(9) < 7);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
